// File: rtl/sign_narrow_unit.sv
// Narrows signed IN_W-bit words to OUT_W-bit fields, flags unrepresentable values and
// buffers two results. Define NARROW_SAT_EN to saturate on overflow instead of wrapping.
module sign_narrow_unit #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [IN_W-1:0]  data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic             ovf_o,
    output logic [CNT_W-1:0] ovf_cnt_o
);

    typedef enum logic [1:0] {
        StEmpty,
        StHalf,
        StFull
    } state_e;

    state_e state_q, state_d;
    logic   ready_q;

    // Head entry drives the outputs; tail holds the second word when FULL.
    logic [OUT_W-1:0] head_data_q, head_data_d;
    logic             head_ovf_q, head_ovf_d;
    logic [OUT_W-1:0] tail_data_q, tail_data_d;
    logic             tail_ovf_q, tail_ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                accept;
    logic                deliver;
    logic [IN_W-OUT_W:0] upper;
    logic                in_ovf;
    logic [OUT_W-1:0]    in_res;

    // Representable iff every bit from the OUT_W sign position upward agrees.
    assign upper  = data_i[IN_W-1:OUT_W-1];
    assign in_ovf = ~((&upper) | ~(|upper));

`ifdef NARROW_SAT_EN
    logic [OUT_W-1:0] sat_val;

    always_comb begin
        sat_val = data_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        in_res  = in_ovf ? sat_val : data_i[OUT_W-1:0];
    end
`else
    always_comb begin
        in_res = data_i[OUT_W-1:0];
    end
`endif

    assign accept  = valid_i & ready_q;
    assign valid_o = (state_q != StEmpty);
    assign deliver = valid_o & ready_i;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ovf_d  = head_ovf_q;
        tail_data_d = tail_data_q;
        tail_ovf_d  = tail_ovf_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d     = StHalf;
                    head_data_d = in_res;
                    head_ovf_d  = in_ovf;
                end
            end
            StHalf: begin
                if (accept && !deliver) begin
                    state_d     = StFull;
                    tail_data_d = in_res;
                    tail_ovf_d  = in_ovf;
                end else if (!accept && deliver) begin
                    state_d = StEmpty;
                end else if (accept && deliver) begin
                    head_data_d = in_res;
                    head_ovf_d  = in_ovf;
                end
            end
            StFull: begin
                if (deliver) begin
                    state_d     = StHalf;
                    head_data_d = tail_data_q;
                    head_ovf_d  = tail_ovf_q;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (deliver && head_ovf_q && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StEmpty;
            ready_q     <= 1'b1;
            head_data_q <= '0;
            head_ovf_q  <= 1'b0;
            tail_data_q <= '0;
            tail_ovf_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= (state_d != StFull);
            head_data_q <= head_data_d;
            head_ovf_q  <= head_ovf_d;
            tail_data_q <= tail_data_d;
            tail_ovf_q  <= tail_ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ready_o   = ready_q;
    assign data_o    = head_data_q;
    assign ovf_o     = head_ovf_q;
    assign ovf_cnt_o = cnt_q;

endmodule

// File: tb/tb_sign_narrow_unit.sv
// Scoreboard bench for sign_narrow_unit: driver pushes expected results, monitor pops on deliver.
module tb_sign_narrow_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clr_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] data_o;
    logic        ovf_o;
    logic [7:0]  ovf_cnt_o;

    typedef struct packed {
        logic [15:0] d;
        logic        o;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   failures  = 0;
    int   cnt_m     = 0;

    always #5 clk_i = ~clk_i;

    sign_narrow_unit #(
        .IN_W (32),
        .OUT_W(16),
        .CNT_W(8)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (clr_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_o   (data_o),
        .ovf_o    (ovf_o),
        .ovf_cnt_o(ovf_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counter model compared before its update, results popped on each deliver.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (!rst_i) begin
            cnt_m = 0;
        end else begin
            check("ovf_cnt_o", {24'd0, ovf_cnt_o}, cnt_m);
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    failures++;
                    $display("FAIL unexpected_output: got data 0x%0h, expected no output", data_o);
                end else begin
                    e = sb.pop_front();
                    check("data_o", {16'd0, data_o}, {16'd0, e.d});
                    check("ovf_o", {31'd0, ovf_o}, {31'd0, e.o});
                    if (clr_i) cnt_m = 0;
                    else if (e.o && cnt_m < 255) cnt_m++;
                end
            end else if (clr_i) begin
                cnt_m = 0;
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [15:0] e_sat, input logic [15:0] e_wrap,
                        input logic e_o, output int waits);
        exp_t e;
`ifdef NARROW_SAT_EN
        e.d = e_sat;
`else
        e.d = e_wrap;
`endif
        e.o     = e_o;
        valid_i = 1'b1;
        data_i  = d;
        waits   = 0;
        @(negedge clk_i);
        while (!ready_o && waits < 50) begin
            waits++;
            @(negedge clk_i);
        end
        if (!ready_o) begin
            tests_run++;
            failures++;
            $display("FAIL send_timeout: got ready_o 0 after %0d cycles, expected 1", waits);
            @(posedge clk_i);
            #1 valid_i = 1'b0;
            return;
        end
        sb.push_back(e);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (sb.size() != 0) begin
            tests_run++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int w;
        rst_i   = 1'b0;
        clr_i   = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid_o", {31'd0, valid_o}, 0);
        check("rst_data_o", {16'd0, data_o}, 0);
        check("rst_ovf_o", {31'd0, ovf_o}, 0);
        check("rst_ovf_cnt", {24'd0, ovf_cnt_o}, 0);
        #2 rst_i = 1'b1;
        ready_i = 1'b1;
        @(negedge clk_i);
        check("ready_after_rst", {31'd0, ready_o}, 1);
        @(posedge clk_i);
        #1;

        // Reset while FULL and stalled
        send(32'h8000_0000, 16'h8000, 16'h0000, 1'b1, w);
        drain();
        check("cnt_one", {24'd0, ovf_cnt_o}, 1);
        ready_i = 1'b0;
        send(32'h0000_1111, 16'h1111, 16'h1111, 1'b0, w);
        send(32'h0012_0000, 16'h7FFF, 16'h0000, 1'b1, w);
        @(negedge clk_i);
        check("full_ready_o", {31'd0, ready_o}, 0);
        check("full_valid_o", {31'd0, valid_o}, 1);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        sb.delete();
        #1;
        check("midrst_valid_o", {31'd0, valid_o}, 0);
        check("midrst_data_o", {16'd0, data_o}, 0);
        check("midrst_ovf_o", {31'd0, ovf_o}, 0);
        check("midrst_ovf_cnt", {24'd0, ovf_cnt_o}, 0);
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("post_rst_ready", {31'd0, ready_o}, 1);
            check("no_stale_valid", {31'd0, valid_o}, 0);
        end
        @(posedge clk_i);
        #1;

        // In-range and overflow vectors, single-cycle latency from EMPTY
        for (int i = 0; i < 9; i++) begin
            logic [31:0] vin;
            logic [15:0] vs, vw;
            logic        vo;
            case (i)
                0: begin vin = 32'hFFFF_8000; vs = 16'h8000; vw = 16'h8000; vo = 1'b0; end
                1: begin vin = 32'h0000_7FFF; vs = 16'h7FFF; vw = 16'h7FFF; vo = 1'b0; end
                2: begin vin = 32'h0000_0000; vs = 16'h0000; vw = 16'h0000; vo = 1'b0; end
                3: begin vin = 32'hFFFF_FFFF; vs = 16'hFFFF; vw = 16'hFFFF; vo = 1'b0; end
                4: begin vin = 32'h0001_2345; vs = 16'h7FFF; vw = 16'h2345; vo = 1'b1; end
                5: begin vin = 32'h8000_0000; vs = 16'h8000; vw = 16'h0000; vo = 1'b1; end
                6: begin vin = 32'hFFFF_7FFF; vs = 16'h8000; vw = 16'h7FFF; vo = 1'b1; end
                7: begin vin = 32'h0000_8000; vs = 16'h7FFF; vw = 16'h8000; vo = 1'b1; end
                default: begin vin = 32'h0000_1234; vs = 16'h1234; vw = 16'h1234; vo = 1'b0; end
            endcase
            drain();
            check("idle_valid_o", {31'd0, valid_o}, 0);
            send(vin, vs, vw, vo, w);
            @(negedge clk_i);
            check("latency_valid_o", {31'd0, valid_o}, 1);
        end
        drain();

        // Backpressure: A and B fill the buffer, C is held until ready_i returns
        ready_i = 1'b0;
        send(32'h0000_0A0A, 16'h0A0A, 16'h0A0A, 1'b0, w);
        send(32'hFFFF_B0B0, 16'hB0B0, 16'hB0B0, 1'b0, w);
        valid_i = 1'b1;
        data_i  = 32'h7FFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("stall_ready_o", {31'd0, ready_o}, 0);
            check("stall_valid_o", {31'd0, valid_o}, 1);
            check("stall_data_o", {16'd0, data_o}, 32'h0A0A);
        end
        @(posedge clk_i);
        #1 ready_i = 1'b1;
        send(32'h7FFF_FFFF, 16'h7FFF, 16'hFFFF, 1'b1, w);
        drain();

        // Full-rate burst: ready_o never drops
        for (int i = 0; i < 10; i++) begin
            logic [31:0] v;
            v = 32'(i * 1000) - 32'd5000;
            send(v, v[15:0], v[15:0], 1'b0, w);
            check("burst_no_wait", w, 0);
        end
        drain();

        // Counter saturation, then clear beating a same-cycle increment
        for (int i = 0; i < 300; i++) begin
            send(32'h0001_2345, 16'h7FFF, 16'h2345, 1'b1, w);
        end
        drain();
        check("cnt_saturated", {24'd0, ovf_cnt_o}, 255);
        send(32'h0001_2345, 16'h7FFF, 16'h2345, 1'b1, w);
        clr_i = 1'b1;
        @(posedge clk_i);
        #1 clr_i = 1'b0;
        check("clr_wins", {24'd0, ovf_cnt_o}, 0);
        send(32'h8000_0000, 16'h8000, 16'h0000, 1'b1, w);
        drain();
        check("cnt_after_clr", {24'd0, ovf_cnt_o}, 1);

        repeat (2) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
